// File: rtl/subservient_dbg_loader.sv
// Firmware loader: packs a byte stream little-endian into 32-bit words and writes
// each word over the subservient debug Wishbone port while holding the core in debug mode.
module subservient_dbg_loader #(
    parameter int memsize     = 1024,
    parameter int aw          = $clog2(memsize),
    parameter int START_DELAY = 10,
    parameter int END_DELAY   = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte_data,
    input  logic          i_byte_last,
    output logic          o_byte_ready,
    output logic          o_debug_mode,
    output logic [31:0]   o_wb_dbg_adr,
    output logic [31:0]   o_wb_dbg_dat,
    output logic [3:0]    o_wb_dbg_sel,
    output logic          o_wb_dbg_we,
    output logic          o_wb_dbg_stb,
    input  logic          i_wb_dbg_ack,
    output logic          o_done,
    output logic          o_error,
    output logic [aw:0]   o_byte_count
);

    localparam int MAXD = (START_DELAY > END_DELAY) ? START_DELAY : END_DELAY;
    localparam int DW   = (MAXD > 1) ? $clog2(MAXD) : 1;
    localparam int CW   = aw + 1;

    localparam logic [DW-1:0] START_LOAD = DW'(START_DELAY - 1);
    localparam logic [DW-1:0] END_LOAD   = DW'(END_DELAY - 1);
    localparam logic [DW-1:0] DLY_ONE    = DW'(1);
    localparam logic [CW-1:0] MEM_FULL   = CW'(memsize);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        COLLECT,
        WRITE,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q;
    logic [DW-1:0]   dly_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     dat_q;
    logic [31:0]     adr_q;
    logic            stb_q;
    logic            ready_q;
    logic            dbg_q;
    logic            done_q;
    logic            err_q;
    logic            last_q;

    logic accept;
    logic full;
    logic word_end;

    assign accept   = i_byte_valid & ready_q;
    assign full     = (count_q == MEM_FULL);
    assign word_end = (count_q[1:0] == 2'd3) | i_byte_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            dly_q   <= '0;
            count_q <= '0;
            dat_q   <= '0;
            adr_q   <= '0;
            stb_q   <= 1'b0;
            ready_q <= 1'b0;
            dbg_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (i_start) begin
                        state_q <= SETTLE;
                        dly_q   <= START_LOAD;
                        dbg_q   <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                        count_q <= '0;
                        dat_q   <= '0;
                    end
                end
                SETTLE: begin
                    if (dly_q == '0) begin
                        state_q <= COLLECT;
                        ready_q <= 1'b1;
                    end else begin
                        dly_q <= dly_q - DLY_ONE;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        if (full) begin
                            // Memory is full, so any partial word was already flushed.
                            err_q <= 1'b1;
                            if (i_byte_last) begin
                                state_q <= DRAIN;
                                ready_q <= 1'b0;
                                dly_q   <= END_LOAD;
                            end
                        end else begin
                            dat_q[{count_q[1:0], 3'b000} +: 8] <= i_byte_data;
                            count_q <= count_q + CNT_ONE;
                            if (word_end) begin
                                state_q <= WRITE;
                                ready_q <= 1'b0;
                                stb_q   <= 1'b1;
                                last_q  <= i_byte_last;
                                adr_q   <= {{(32-aw){1'b0}}, count_q[aw-1:2], 2'b00};
                            end
                        end
                    end
                end
                WRITE: begin
                    if (i_wb_dbg_ack) begin
                        stb_q <= 1'b0;
                        dat_q <= '0;
                        if (last_q) begin
                            state_q <= DRAIN;
                            dly_q   <= END_LOAD;
                        end else begin
                            state_q <= COLLECT;
                            ready_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (dly_q == '0) begin
                        state_q <= DONE;
                        dbg_q   <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        dly_q <= dly_q - DLY_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_byte_ready = ready_q;
    assign o_debug_mode = dbg_q;
    assign o_wb_dbg_adr = adr_q;
    assign o_wb_dbg_dat = dat_q;
    assign o_wb_dbg_sel = {4{stb_q}};
    assign o_wb_dbg_we  = stb_q;
    assign o_wb_dbg_stb = stb_q;
    assign o_done       = done_q;
    assign o_error      = err_q;
    assign o_byte_count = count_q;

endmodule

// File: tb/tb_subservient_dbg_loader.sv
// Bench for subservient_dbg_loader: event-level reference model compared every cycle,
// directed loads with literal expectations, then randomized loads.
module tb_subservient_dbg_loader;

    localparam int MEM = 16;
    localparam int SD  = 3;
    localparam int ED  = 4;
    localparam int AW  = $clog2(MEM);

    logic          clk;
    logic          rst;
    logic          i_start;
    logic          i_byte_valid;
    logic [7:0]    i_byte_data;
    logic          i_byte_last;
    logic          o_byte_ready;
    logic          o_debug_mode;
    logic [31:0]   o_wb_dbg_adr;
    logic [31:0]   o_wb_dbg_dat;
    logic [3:0]    o_wb_dbg_sel;
    logic          o_wb_dbg_we;
    logic          o_wb_dbg_stb;
    logic          i_wb_dbg_ack;
    logic          o_done;
    logic          o_error;
    logic [AW:0]   o_byte_count;

    subservient_dbg_loader #(
        .memsize(MEM),
        .START_DELAY(SD),
        .END_DELAY(ED)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_start(i_start),
        .i_byte_valid(i_byte_valid),
        .i_byte_data(i_byte_data),
        .i_byte_last(i_byte_last),
        .o_byte_ready(o_byte_ready),
        .o_debug_mode(o_debug_mode),
        .o_wb_dbg_adr(o_wb_dbg_adr),
        .o_wb_dbg_dat(o_wb_dbg_dat),
        .o_wb_dbg_sel(o_wb_dbg_sel),
        .o_wb_dbg_we(o_wb_dbg_we),
        .o_wb_dbg_stb(o_wb_dbg_stb),
        .i_wb_dbg_ack(i_wb_dbg_ack),
        .o_done(o_done),
        .o_error(o_error),
        .o_byte_count(o_byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    // Image being loaded; byte k of the stream is img[k].
    logic [7:0] img [0:63];

    // Reference model: tracks the load as a sequence of events (start, accepts, acks).
    int          m_count;
    bit          m_ready, m_stb, m_dbg, m_done, m_err, m_lastword;
    logic [31:0] m_adr, m_dat;
    longint      mcyc = 0, ready_on_at = -1, drain_end = -1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_count = 0; m_ready = 0; m_stb = 0; m_dbg = 0; m_done = 0; m_err = 0;
            m_lastword = 0; m_adr = 0; m_dat = 0; ready_on_at = -1; drain_end = -1;
        end else begin
            mcyc++;
            if (m_ready && i_byte_valid) begin
                if (m_count == MEM) begin
                    m_err = 1;
                    if (i_byte_last) begin
                        m_ready = 0;
                        drain_end = mcyc + ED;
                    end
                end else begin
                    m_count++;
                    if (m_count % 4 == 0 || i_byte_last) begin
                        m_ready = 0;
                        m_stb = 1;
                        m_lastword = i_byte_last;
                        m_adr = 32'(((m_count - 1) / 4) * 4);
                        m_dat = 0;
                        for (int k = 0; k < 4; k++)
                            if (int'(m_adr) + k < m_count) m_dat[8*k +: 8] = img[int'(m_adr) + k];
                    end
                end
            end else if (m_stb && i_wb_dbg_ack) begin
                m_stb = 0;
                if (m_lastword) drain_end = mcyc + ED;
                else m_ready = 1;
            end
            if (i_start && !m_dbg) begin
                m_dbg = 1; m_done = 0; m_err = 0; m_count = 0;
                ready_on_at = mcyc + SD;
            end
            if (mcyc == ready_on_at) m_ready = 1;
            if (mcyc == drain_end) begin
                m_dbg = 0;
                m_done = 1;
            end
        end
    end

    // Ack responder: fixed or random wait per write, optional stray acks while stb is low.
    int ack_delay = 0;
    bit ack_noise = 0;
    int ack_seen  = 0;
    int cur_delay = 0;

    always @(negedge clk) begin
        #1;
        if (o_wb_dbg_stb) begin
            ack_seen++;
            i_wb_dbg_ack = (ack_seen > cur_delay);
        end else begin
            ack_seen = 0;
            cur_delay = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
            i_wb_dbg_ack = ack_noise && ($urandom_range(0, 3) == 0);
        end
    end

    // Per-cycle compare against the model, plus transaction log and edge timestamps.
    logic [63:0] wlog [$];
    int          nc = 0, e_s = -1, e_dbg_rise = -1, e_dbg_fall = -1, e_first_stb = -1, e_last_ack = -1;
    int          stb_run = 0, last_stb_len = 0;
    bit          prev_stb = 0, prev_dbg = 0;
    logic [31:0] prev_adr = 0, prev_dat = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_stb = 0; prev_dbg = 0; stb_run = 0;
        end else begin
            nc++;
            if (chk_en) begin
                check("ready", o_byte_ready, m_ready);
                check("debug_mode", o_debug_mode, m_dbg);
                check("done", o_done, m_done);
                check("error", o_error, m_err);
                check("byte_count", 32'(o_byte_count), m_count);
                check("stb", o_wb_dbg_stb, m_stb);
                if (m_stb) begin
                    check("we", o_wb_dbg_we, 1);
                    check("sel", o_wb_dbg_sel, 4'hF);
                    check("adr", o_wb_dbg_adr, m_adr);
                    check("dat", o_wb_dbg_dat, m_dat);
                end
            end
            if (i_start && !prev_dbg) begin
                e_s = nc;
                e_first_stb = -1;
            end
            if (o_debug_mode && !prev_dbg) e_dbg_rise = nc;
            if (!o_debug_mode && prev_dbg) e_dbg_fall = nc;
            if (o_wb_dbg_stb && !prev_stb && e_first_stb < 0) e_first_stb = nc;
            if (prev_stb && i_wb_dbg_ack) begin
                wlog.push_back({prev_adr, prev_dat});
                e_last_ack = nc;
                last_stb_len = stb_run;
            end
            stb_run = o_wb_dbg_stb ? stb_run + 1 : 0;
            prev_stb = o_wb_dbg_stb;
            prev_dbg = o_debug_mode;
            prev_adr = o_wb_dbg_adr;
            prev_dat = o_wb_dbg_dat;
        end
    end

    function automatic logic [63:0] getw(input int i);
        if (i < wlog.size()) return wlog[i];
        return '1;
    endfunction

    task automatic start_load();
        wlog.delete();
        @(negedge clk); #1;
        i_start = 1'b1;
        @(negedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic feed(input int len, input int density, input bit stray_start);
        int idx = 0;
        int cyc = 0;
        bit rdy = 0;
        while (idx < len && cyc < 3000) begin
            @(negedge clk); #1;
            cyc++;
            if (i_byte_valid && rdy) idx++;
            if (idx < len) begin
                i_byte_valid = ($urandom_range(1, 100) <= density);
                i_byte_data  = img[idx];
                i_byte_last  = (idx == len - 1);
            end else begin
                i_byte_valid = 1'b0;
                i_byte_last  = 1'b0;
                i_byte_data  = 8'h00;
            end
            i_start = stray_start && ($urandom_range(0, 15) == 0);
            rdy = o_byte_ready;
        end
        i_start = 1'b0;
        i_byte_valid = 1'b0;
        check("feed_bytes", idx, len);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!o_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #2;
        check("done_seen", o_done, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 900000", $time);
        $fatal(1);
    end

    initial begin
        int len;
        rst = 1'b0; i_start = 1'b0; i_byte_valid = 1'b0; i_byte_data = 8'h00;
        i_byte_last = 1'b0; i_wb_dbg_ack = 1'b0;
        #1 rst = 1'b1;
        #3;
        check("rst_stb", o_wb_dbg_stb, 0);
        check("rst_dbg", o_debug_mode, 0);
        check("rst_ready", o_byte_ready, 0);
        check("rst_done", o_done, 0);
        check("rst_error", o_error, 0);
        check("rst_count", 32'(o_byte_count), 0);
        check("rst_adr", o_wb_dbg_adr, 0);
        check("rst_dat", o_wb_dbg_dat, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // Bytes 00..07, zero-wait ack.
        for (int i = 0; i < 8; i++) img[i] = 8'(i);
        start_load();
        feed(8, 100, 0);
        wait_done();
        check("t1_nwrites", wlog.size(), 2);
        check("t1_w0_adr", getw(0)[63:32], 32'h0);
        check("t1_w0_dat", getw(0)[31:0], 32'h03020100);
        check("t1_w1_adr", getw(1)[63:32], 32'h4);
        check("t1_w1_dat", getw(1)[31:0], 32'h07060504);
        check("t1_count", 32'(o_byte_count), 8);
        check("t1_dbg", o_debug_mode, 0);
        check("t1_dbg_rise", e_dbg_rise, e_s);
        check("t1_first_stb_late", (e_first_stb - e_s) >= SD + 1, 1);
        check("t1_drain_len", e_dbg_fall - e_last_ack, ED);
        $display("load 1: %0d writes, count=%0d", wlog.size(), o_byte_count);

        // Partial final word is zero-padded.
        img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD; img[4] = 8'hEE;
        start_load();
        feed(5, 100, 0);
        wait_done();
        check("t2_nwrites", wlog.size(), 2);
        check("t2_w0_adr", getw(0)[63:32], 32'h0);
        check("t2_w0_dat", getw(0)[31:0], 32'hDDCCBBAA);
        check("t2_w1_adr", getw(1)[63:32], 32'h4);
        check("t2_w1_dat", getw(1)[31:0], 32'h000000EE);
        check("t2_count", 32'(o_byte_count), 5);
        $display("load 2: %0d writes, count=%0d", wlog.size(), o_byte_count);

        // Ack delayed three cycles, valid held high throughout.
        for (int i = 0; i < 8; i++) img[i] = 8'($urandom);
        ack_delay = 3;
        start_load();
        feed(8, 100, 0);
        wait_done();
        check("t3_stb_len", last_stb_len, 4);
        check("t3_nwrites", wlog.size(), 2);
        check("t3_w1_dat", getw(1)[31:0], {img[7], img[6], img[5], img[4]});
        $display("load 3: %0d writes, stb held %0d cycles", wlog.size(), last_stb_len);
        ack_delay = 0;

        // Overflow: two bytes beyond memory size, last on the final one.
        for (int i = 0; i < MEM + 2; i++) img[i] = 8'($urandom);
        start_load();
        feed(MEM + 2, 100, 0);
        wait_done();
        check("t4_nwrites", wlog.size(), MEM / 4);
        check("t4_error", o_error, 1);
        check("t4_count", 32'(o_byte_count), MEM);
        check("t4_last_adr", getw(MEM / 4 - 1)[63:32], MEM - 4);
        $display("load 4: %0d writes, error=%0b, count=%0d", wlog.size(), o_error, o_byte_count);

        // Randomized loads: lengths across the memory boundary, random gaps and ack waits.
        ack_delay = -1;
        ack_noise = 1;
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(1, MEM + 6);
            for (int i = 0; i < len; i++) img[i] = 8'($urandom);
            start_load();
            feed(len, $urandom_range(30, 100), 1);
            wait_done();
            check("rand_count", 32'(o_byte_count), (len > MEM) ? MEM : len);
            check("rand_error", o_error, len > MEM);
            check("rand_nwrites", wlog.size(), (((len > MEM) ? MEM : len) + 3) / 4);
            $display("random load %0d: len=%0d writes=%0d error=%0b", t, len, wlog.size(), o_error);
        end
        ack_noise = 0;

        // Asynchronous reset while a write is stalled waiting for ack.
        ack_delay = 1000;
        for (int i = 0; i < 4; i++) img[i] = 8'($urandom);
        start_load();
        feed(4, 100, 0);
        repeat (3) @(negedge clk);
        #2;
        check("t5_stb_before_rst", o_wb_dbg_stb, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_stb", o_wb_dbg_stb, 0);
        check("t5_rst_dbg", o_debug_mode, 0);
        check("t5_rst_ready", o_byte_ready, 0);
        @(negedge clk); #1;
        rst = 1'b0;
        ack_delay = 0;
        start_load();
        feed(4, 100, 0);
        wait_done();
        check("t5_nwrites", wlog.size(), 1);
        check("t5_w0_dat", getw(0)[31:0], {img[3], img[2], img[1], img[0]});
        check("t5_count", 32'(o_byte_count), 4);
        $display("load 5 after reset: %0d writes, count=%0d", wlog.size(), o_byte_count);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
